// File: rtl/tariff_bill_if.sv
// tariff_bill_if: billing-payment bus between the bill generator (slave) and the metering/payment side (master).
// Master drives the meter pulses, the period close, the adjustments and bill_ready.
// Slave drives bill_valid, bill_amount, units_billed, busy and count_overflow.
interface tariff_bill_if;
  logic        meter_pulse;
  logic        cycle_end;
  logic        adj_valid;
  logic        short_payment;
  logic        excess_payment;
  logic [15:0] adjustment_amount;
  logic        bill_ready;
  logic        bill_valid;
  logic [15:0] bill_amount;
  logic [15:0] units_billed;
  logic        busy;
  logic        count_overflow;
  modport master(
    output meter_pulse, cycle_end, adj_valid, short_payment, excess_payment, adjustment_amount, bill_ready,
    input  bill_valid, bill_amount, units_billed, busy, count_overflow
  );
  modport slave(
    input  meter_pulse, cycle_end, adj_valid, short_payment, excess_payment, adjustment_amount, bill_ready,
    output bill_valid, bill_amount, units_billed, busy, count_overflow
  );
endinterface

// File: rtl/tariff_bill_generator.sv
// tariff_bill_generator: counts energy pulses per billing period and issues the period's bill over a valid/ready handshake.
// Ports: clk, reset (async, active-high), io_bill (tariff_bill_if.slave: meter/period/adjustment inputs, bill outputs).
// Macro BILL_TIERED_TARIFF_EN selects the two-tier energy charge; undefined bills every unit at RATE_LOW.
module tariff_bill_generator #(
  parameter int RATE_LOW     = 5,
  parameter int RATE_HIGH    = 8,
  parameter int TIER_LIMIT   = 100,
  parameter int FIXED_CHARGE = 50
) (
  input logic         clk,
  input logic         reset,
  tariff_bill_if.slave io_bill
);
  typedef enum logic [1:0] {ACCUM, CALC, PRESENT} state_t;
`ifdef BILL_TIERED_TARIFF_EN
  localparam int RATE_ABOVE = RATE_HIGH;
`else
  // flat tariff: units above the tier boundary cost the same as those below
  localparam int RATE_ABOVE = RATE_LOW + 0 * RATE_HIGH;
`endif
  state_t             r_state;
  logic [15:0]        r_count, r_units, r_bill;
  logic [23:0]        r_arrears, r_credit;
  logic               r_valid, r_busy, r_ovf;
  logic [31:0]        w_low, w_high, w_gross;
  logic signed [33:0] w_net;
  logic               w_neg, w_big, w_snap, w_short, w_excess;
  logic [15:0]        w_calc_bill;
  logic [23:0]        w_calc_arr, w_calc_cred, w_arr_base, w_cred_base;
  logic [24:0]        w_arr_sum, w_cred_sum;
  always_comb begin
    w_low       = ({16'd0, r_units} > 32'(TIER_LIMIT)) ? 32'(TIER_LIMIT) : {16'd0, r_units};
    w_high      = {16'd0, r_units} - w_low;
    w_gross     = 32'(FIXED_CHARGE) + w_low * 32'(RATE_LOW) + w_high * 32'(RATE_ABOVE);
    w_net       = $signed({2'b00, w_gross}) + $signed({10'd0, r_arrears}) - $signed({10'd0, r_credit});
    w_neg       = w_net < 0;
    w_big       = w_net > 34'sh0FFFF;
    w_calc_bill = w_neg ? 16'd0 : w_big ? 16'hFFFF : w_net[15:0];
    w_calc_arr  = !w_big ? 24'd0 : (w_net - 34'sh0FFFF > 34'sh0FFFFFF) ? 24'hFFFFFF : 24'(w_net - 34'sh0FFFF);
    w_calc_cred = w_neg ? 24'(-w_net) : 24'd0;
    w_snap      = (r_state == ACCUM) && io_bill.cycle_end;
    w_short     = io_bill.adj_valid && io_bill.short_payment && !io_bill.excess_payment;
    w_excess    = io_bill.adj_valid && io_bill.excess_payment && !io_bill.short_payment;
    // an adjustment arriving in CALC lands on top of the freshly settled balance
    w_arr_base  = (r_state == CALC) ? w_calc_arr : r_arrears;
    w_cred_base = (r_state == CALC) ? w_calc_cred : r_credit;
    w_arr_sum   = {1'b0, w_arr_base} + (w_short ? {9'd0, io_bill.adjustment_amount} : 25'd0);
    w_cred_sum  = {1'b0, w_cred_base} + (w_excess ? {9'd0, io_bill.adjustment_amount} : 25'd0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ACCUM;
      r_count   <= '0;
      r_units   <= '0;
      r_bill    <= '0;
      r_arrears <= '0;
      r_credit  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_arrears <= w_arr_sum[24] ? 24'hFFFFFF : w_arr_sum[23:0];
      r_credit  <= w_cred_sum[24] ? 24'hFFFFFF : w_cred_sum[23:0];
      if (w_snap) begin
        r_units <= r_count;
        r_count <= {15'd0, io_bill.meter_pulse};
        r_ovf   <= 1'b0;
      end else if (io_bill.meter_pulse && r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
        r_ovf   <= r_ovf || (r_count == 16'hFFFE);
      end
      case (r_state)
        ACCUM: if (io_bill.cycle_end) begin
          r_state <= CALC;
          r_busy  <= 1'b1;
        end
        CALC: begin
          r_bill  <= w_calc_bill;
          r_valid <= 1'b1;
          r_state <= PRESENT;
        end
        PRESENT: if (io_bill.bill_ready) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end
  assign io_bill.bill_valid     = r_valid;
  assign io_bill.bill_amount    = r_bill;
  assign io_bill.units_billed   = r_units;
  assign io_bill.busy           = r_busy;
  assign io_bill.count_overflow = r_ovf;
endmodule

// File: tb/tb_tariff_bill_generator.sv
// tb_tariff_bill_generator: table-driven and randomized check of tariff_bill_generator against a cycle-level reference model.
module tb_tariff_bill_generator;
  localparam longint RL = 5, RH = 8, TL = 100, FC = 50, SAT24 = 64'hFFFFFF;
  logic clk = 1'b0;
  logic reset = 1'b1;
  tariff_bill_if bif();
  tariff_bill_generator dut(.clk(clk), .reset(reset), .io_bill(bif));
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  int     m_phase;
  longint m_count, m_units, m_arr, m_cred, m_bill;
  typedef struct {int pulses; int kind; int amt; int bill; int units;} vec_t;
  vec_t tbl[6];
  function automatic longint energy(longint u);
`ifdef BILL_TIERED_TARIFF_EN
    return (u < TL ? u : TL) * RL + (u > TL ? u - TL : 0) * RH;
`else
    return u * RL;
`endif
  endfunction
  function automatic longint lmin(longint a, longint b);
    return a < b ? a : b;
  endfunction
  task automatic model_reset();
    m_phase = 0; m_count = 0; m_units = 0; m_arr = 0; m_cred = 0; m_bill = 0;
  endtask
  task automatic model(input bit p, ce, av, sh, ex, input int amt, input bit rdy);
    longint a_s, a_e, net;
    a_s = (av && sh && !ex) ? longint'(amt) : 0;
    a_e = (av && ex && !sh) ? longint'(amt) : 0;
    if (m_phase == 0 && ce) begin
      m_units = lmin(m_count, 65535);
      m_count = p;
      m_phase = 1;
    end else begin
      m_count += p;
      if (m_phase == 1) begin
        net = FC + energy(m_units) + m_arr - m_cred;
        if (net < 0) begin m_bill = 0; m_cred = -net; m_arr = 0; end
        else if (net > 65535) begin m_bill = 65535; m_arr = lmin(net - 65535, SAT24); m_cred = 0; end
        else begin m_bill = net; m_arr = 0; m_cred = 0; end
        m_phase = 2;
      end else if (m_phase == 2 && rdy) m_phase = 0;
    end
    m_arr  = lmin(m_arr + a_s, SAT24);
    m_cred = lmin(m_cred + a_e, SAT24);
  endtask
  task automatic check_model(input string nm);
    bit ev, eb, eo;
    ev = m_phase == 2;
    eb = m_phase != 0;
    eo = m_count >= 65535;
    n_vec++;
    if (bif.bill_valid !== ev || bif.busy !== eb || bif.count_overflow !== eo ||
        bif.bill_amount !== 16'(m_bill) || bif.units_billed !== 16'(m_units)) begin
      n_err++;
      $display("FAIL %s @%0t: got valid=%b busy=%b ovf=%b bill=%0d units=%0d, expected valid=%b busy=%b ovf=%b bill=%0d units=%0d",
               nm, $time, bif.bill_valid, bif.busy, bif.count_overflow, bif.bill_amount, bif.units_billed,
               ev, eb, eo, m_bill, m_units);
    end
  endtask
  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  task automatic step(input bit p, ce, av, sh, ex, input int amt, input bit rdy);
    @(negedge clk);
    bif.meter_pulse = p; bif.cycle_end = ce; bif.adj_valid = av; bif.short_payment = sh;
    bif.excess_payment = ex; bif.adjustment_amount = 16'(amt); bif.bill_ready = rdy;
    @(posedge clk);
    model(p, ce, av, sh, ex, amt, rdy);
    #1 check_model("cycle");
  endtask
  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, rdy);
  endtask
  task automatic pulses(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, rdy);
  endtask
  task automatic run_period(input int n, input int kind, input int amt, input int exp_bill, input int exp_units);
    if (kind != 0) step(0, 0, 1, kind == 1 || kind == 3, kind == 2 || kind == 3, amt, 1);
    pulses(n, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("calc_busy", bif.busy, 1);
    chk("calc_not_valid", bif.bill_valid, 0);
    idle(1);
    chk("bill_valid_at_2", bif.bill_valid, 1);
    chk("bill_amount", bif.bill_amount, exp_bill);
    chk("units_billed", bif.units_billed, exp_units);
    idle(1);
    chk("handshake_valid_low", bif.bill_valid, 0);
    chk("handshake_idle", bif.busy, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    bif.meter_pulse = 0; bif.cycle_end = 0; bif.adj_valid = 0; bif.short_payment = 0;
    bif.excess_payment = 0; bif.adjustment_amount = 0; bif.bill_ready = 0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_model("reset_async");
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    tbl[0] = '{40, 0, 0, 250, 40};
`ifdef BILL_TIERED_TARIFF_EN
    tbl[1] = '{150, 0, 0, 950, 150};
    tbl[5] = '{140, 0, 0, 170, 140};
`else
    tbl[1] = '{150, 0, 0, 800, 150};
    tbl[5] = '{140, 0, 0, 50, 140};
`endif
    tbl[2] = '{40, 1, 300, 550, 40};
    tbl[3] = '{40, 2, 1000, 0, 40};
    tbl[4] = '{0, 0, 0, 0, 0};
    model_reset();
    do_reset();
    check_model("after_reset");
    for (int i = 0; i < 6; i++) run_period(tbl[i].pulses, tbl[i].kind, tbl[i].amt, tbl[i].bill, tbl[i].units);
    pulses(40, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(0);
    step(1, 0, 0, 0, 0, 0, 0); chk("hold_amount", bif.bill_amount, 250); chk("hold_valid", bif.bill_valid, 1);
    step(0, 1, 0, 0, 0, 0, 0); chk("hold_amount", bif.bill_amount, 250); chk("hold_valid", bif.bill_valid, 1);
    step(1, 0, 0, 0, 0, 0, 0); chk("hold_amount", bif.bill_amount, 250); chk("hold_valid", bif.bill_valid, 1);
    step(0, 0, 0, 0, 0, 0, 0); chk("hold_amount", bif.bill_amount, 250); chk("hold_valid", bif.bill_valid, 1);
    step(1, 0, 0, 0, 0, 0, 0); chk("hold_amount", bif.bill_amount, 250); chk("hold_valid", bif.bill_valid, 1);
    idle(1);
    chk("hold_released", bif.bill_valid, 0);
    chk("amount_held_after_hs", bif.bill_amount, 250);
    run_period(0, 0, 0, 65, 3);
    pulses(40, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 100, 1);
    chk("calc_adj_bill", bif.bill_amount, 250);
    idle(1);
    run_period(0, 0, 0, 150, 0);
    run_period(0, 3, 500, 50, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    run_period(0, 0, 0, 55, 1);
    pulses(65536, 1);
    chk("overflow_set", bif.count_overflow, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("overflow_cleared", bif.count_overflow, 0);
    chk("sat_units", bif.units_billed, 65535);
    idle(1);
    chk("sat_bill", bif.bill_amount, 65535);
    idle(1);
    pulses(40, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    idle(0);
    pulses(20, 0);
    do_reset();
    chk("reset_bill", bif.bill_amount, 0);
    chk("reset_units", bif.units_billed, 0);
    run_period(10, 0, 0, 100, 10);
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 600)),
           $urandom_range(0, 2) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tariff_bill_generator.md
# tariff_bill_generator

Issuing end of the billing-payment interface. Counts metered energy pulses over a billing period and computes the bill when the period closes. The bill includes a fixed charge, a tiered energy charge, carried-forward arrears and carried-forward credit. It presents `bill_amount` to the payment processing stage with a valid/ready handshake, and absorbs that stage's short/excess adjustment results into the next bill.

## Interface
Parameters:
- `RATE_LOW`, 5: charge per unit up to `TIER_LIMIT`.
- `RATE_HIGH`, 8: charge per unit above `TIER_LIMIT`.
- `TIER_LIMIT`, 100: units billed at `RATE_LOW`.
- `FIXED_CHARGE`, 50: per-period fixed charge.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `meter_pulse`  in  1  one energy unit per cycle high.
- `cycle_end`  in  1  closes the billing period (one-cycle pulse).
- `adj_valid`  in  1  qualifies the adjustment inputs for one cycle.
- `short_payment`  in  1  adjustment is an underpayment.
- `excess_payment`  in  1  adjustment is an overpayment.
- `adjustment_amount`  in  16  magnitude of the adjustment.
- `bill_ready`  in  1  downstream accepts the bill.
- `bill_valid`  out  1  bill presented.
- `bill_amount`  out  16  bill value; held stable while `bill_valid`=1.
- `units_billed`  out  16  unit count behind the current bill.
- `busy`  out  1  high in CALC and PRESENT.
- `count_overflow`  out  1  sticky; unit counter saturated this period.

## Operation
- FSM states: ACCUM → CALC → PRESENT → ACCUM.
- ACCUM: `cycle_end`=1 → snapshot unit counter into `units_billed`, clear the counter, go to CALC.
- CALC (one cycle):
  - gross = FIXED_CHARGE + energy charge, in 32-bit arithmetic.
  - net = gross + arrears − credit, signed.
  - net < 0 → `bill_amount`=0, credit = −net, arrears = 0.
  - net > 0xFFFF → `bill_amount`=0xFFFF, arrears = net − 0xFFFF, credit = 0.
  - otherwise → `bill_amount`=net, arrears = credit = 0.
  - Go to PRESENT.
- PRESENT: `bill_valid`=1. When `bill_valid` && `bill_ready` at an edge → ACCUM.
- Unit counter:
  - Increments on `meter_pulse` in every state; saturates at 0xFFFF and sets `count_overflow`.
  - A pulse coincident with the snapshot counts toward the new period (counter loads 1).
  - `count_overflow` clears at the snapshot unless that same coincident pulse saturates the counter.
- Adjustment capture (every state), on `adj_valid`:
  - `short_payment`=1 only → arrears += `adjustment_amount`.
  - `excess_payment`=1 only → credit += `adjustment_amount`.
  - Both flags high or both low → ignored.
  - Arrears and credit are 24-bit registers and saturate at 0xFFFFFF.
- `adj_valid` in the CALC cycle: CALC uses the pre-edge arrears/credit. The captured amount is added to the post-CALC result, so nothing is lost.
- `cycle_end` outside ACCUM is ignored; the period simply continues.
- Reset values: state ACCUM; `bill_valid`, `bill_amount`, `units_billed`, `busy`, `count_overflow` = 0; unit counter, arrears, credit = 0.
- Reset mid-operation aborts any pending bill; no bill is re-presented after reset.

## Timing
- `cycle_end` sampled at edge N → CALC during cycle N..N+1 → `bill_valid`=1 and `bill_amount` valid after edge N+1.
- Latency from `cycle_end` to `bill_valid` is 2 cycles.
- Handshake at edge M → `bill_valid`=0 after M. `bill_amount` and `units_billed` hold until the next CALC.
- Back-to-back: the earliest accepted `cycle_end` is the cycle after handshake edge M.
- `busy` = (state ≠ ACCUM), registered with the state.

## Configuration
- Macro: `BILL_TIERED_TARIFF_EN`.
- Defined → energy charge = min(units, TIER_LIMIT)·RATE_LOW + max(units − TIER_LIMIT, 0)·RATE_HIGH.
- Undefined → flat tariff, energy charge = units·RATE_LOW. `RATE_HIGH` and `TIER_LIMIT` are unused.

## Test plan
- 40 pulses, then `cycle_end`, `bill_ready`=1 → `bill_valid` 2 cycles later, `bill_amount`=250, `units_billed`=40; back in ACCUM the cycle after the handshake.
- 150 pulses, then `cycle_end` → `bill_amount`=950 with `BILL_TIERED_TARIFF_EN` defined; 800 without it.
- `adj_valid` with `short_payment`=1, amount 300; then 40 pulses and `cycle_end` → bill 550. Next: `adj_valid` with `excess_payment`=1, amount 1000; 40 pulses → bill 0, credit 750; next period with 0 pulses → bill 0, credit 700.
- Hold `bill_ready`=0 for 5 cycles in PRESENT, with 3 pulses and one `cycle_end` during the wait → `bill_valid` and `bill_amount` stable; the extra `cycle_end` is ignored; the next period's bill is 65.
- `adj_valid` short 100 in the CALC cycle of a 40-unit bill → this bill is 250, the following 0-unit bill is 150. `adj_valid` with both flags high → no change.
- Assert `reset` while PRESENT with 20 pulses pending → all outputs 0 immediately. After release, 10 pulses and `cycle_end` → bill 100 (no stale units).
